// File: rtl/alu_bus_pkg.sv
// Package: alu_bus_pkg
// Shared definitions for the 8-bit ALU control bus. The host-side sequencer
// and the ALU control block both import this package.
//   phase_e     : bus phase codes carried in bus_ctrl[1:0]
//   FUNC_MSB..  : bit positions of the fields inside the ctrl byte
//   seq_state_e : sequencer FSM states
//   pack_ctrl() : builds a ctrl byte from its fields
package alu_bus_pkg;

  typedef enum logic [1:0] {
    PH_LOAD_A = 2'b00,
    PH_LOAD_B = 2'b01,
    PH_CALC   = 2'b10,
    PH_STATUS = 2'b11
  } phase_e;

  localparam int FUNC_MSB  = 7;
  localparam int FUNC_LSB  = 3;
  localparam int CARRY_BIT = 2;
  localparam int PHASE_MSB = 1;

  typedef enum logic [2:0] {
    IDLE,
    S_A,
    S_B,
    S_CALC,
    S_STAT,
    RESP
  } seq_state_e;

  function automatic logic [7:0] pack_ctrl(input logic [4:0] func,
                                           input logic       carry,
                                           input phase_e     phase);
    logic [7:0] ctrl;
    ctrl                    = '0;
    ctrl[FUNC_MSB:FUNC_LSB] = func;
    ctrl[CARRY_BIT]         = carry;
    ctrl[PHASE_MSB:0]       = phase;
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_bus_sequencer_if.sv
// Interface: alu_bus_sequencer_if
// Bundles the request port, the response port and the ALU control bus of the
// sequencer.
//   slave  : the sequencer (takes requests, drives responses and the bus)
//   master : the host and ALU side (issues requests, takes responses, returns
//            the ALU output byte on bus_data_i)
// Signals:
//   req_valid/req_ready, req_a, req_b, req_func, req_carry : request
//   rsp_valid/rsp_ready, rsp_result, rsp_flags, rsp_carry  : response
//   bus_data_o, bus_ctrl_o : bytes to the ALU;  bus_data_i : byte from the ALU
interface alu_bus_sequencer_if;

  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [4:0] req_func;
  logic       req_carry;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [1:0] rsp_flags;
  logic       rsp_carry;

  logic [7:0] bus_data_o;
  logic [7:0] bus_ctrl_o;
  logic [7:0] bus_data_i;

  modport slave (
    input  req_valid, req_a, req_b, req_func, req_carry,
    output req_ready,
    output rsp_valid, rsp_result, rsp_flags, rsp_carry,
    input  rsp_ready,
    output bus_data_o, bus_ctrl_o,
    input  bus_data_i
  );

  modport master (
    output req_valid, req_a, req_b, req_func, req_carry,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_flags, rsp_carry,
    output rsp_ready,
    input  bus_data_o, bus_ctrl_o,
    output bus_data_i
  );

endinterface

// File: rtl/alu_phase_timer.sv
// Module: alu_phase_timer
// Loadable down-counter that times how long each bus phase is held.
// Counts down to zero and then stays there until reloaded.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (takes priority over counting)
//   load_val   : reload value, normally PHASE_HOLD-1
//   done       : high while the count is zero (last cycle of a phase)
module alu_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/alu_bus_sequencer.sv
// Module: alu_bus_sequencer
// Host-side driver for the 8-bit ALU control bus. Takes one operation on the
// request port, drives LOAD_A, LOAD_B, CALC and STATUS for PHASE_HOLD cycles
// each, captures the ALU byte on the last CALC and last STATUS cycle, and
// returns result/flags/carry on the response port. All outputs are registered.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request, response and ALU bus signals (slave side)
//   busy       : high in every state except IDLE
module alu_bus_sequencer
  import alu_bus_pkg::*;
#(
  parameter int PHASE_HOLD = 4,  // legal 4..15
  parameter int CNT_W      = 4   // must hold PHASE_HOLD-1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_bus_sequencer_if.slave  bus,
  output logic                busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PHASE_HOLD - 1);

  seq_state_e state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [4:0] func_q, func_d;
  logic       carry_q, carry_d;

  logic       rsp_valid_d;
  logic [7:0] rsp_result_d;
  logic [1:0] rsp_flags_d;
  logic       rsp_carry_d;
  logic [7:0] bus_data_d, bus_ctrl_d;

  logic timer_load, timer_done;

  alu_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (HOLD_LAST),
    .done     (timer_done)
  );

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    func_d       = func_q;
    carry_d      = carry_q;
    rsp_valid_d  = bus.rsp_valid;
    rsp_result_d = bus.rsp_result;
    rsp_flags_d  = bus.rsp_flags;
    rsp_carry_d  = bus.rsp_carry;
    timer_load   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          a_d        = bus.req_a;
          b_d        = bus.req_b;
          func_d     = bus.req_func;
          carry_d    = bus.req_carry;
          timer_load = 1'b1;
          state_d    = S_A;
        end
      end
      S_A: begin
        if (timer_done) begin
          timer_load = 1'b1;
          state_d    = S_B;
        end
      end
      S_B: begin
        if (timer_done) begin
          timer_load = 1'b1;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        // The ALU output has settled by the last CALC cycle.
        if (timer_done) begin
          rsp_result_d = bus.bus_data_i;
          timer_load   = 1'b1;
          state_d      = S_STAT;
        end
      end
      S_STAT: begin
        if (timer_done) begin
          rsp_flags_d = bus.bus_data_i[1:0];
          rsp_carry_d = bus.bus_data_i[2];
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus bytes are decoded from the next state so they leave the flops
    // aligned with the state they belong to.
    bus_data_d = '0;
    bus_ctrl_d = '0;
    case (state_d)
      S_A: begin
        bus_data_d = a_d;
        bus_ctrl_d = pack_ctrl(func_d, carry_d, PH_LOAD_A);
      end
      S_B: begin
        bus_data_d = b_d;
        bus_ctrl_d = pack_ctrl(func_d, carry_d, PH_LOAD_B);
      end
      S_CALC:       bus_ctrl_d = pack_ctrl(func_d, carry_d, PH_CALC);
      S_STAT, RESP: bus_ctrl_d = pack_ctrl(func_d, carry_d, PH_STATUS);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset too; there are only a few of them
      // and it keeps the idle bus and response ports at a known zero.
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      func_q         <= '0;
      carry_q        <= 1'b0;
      bus.req_ready  <= 1'b1;
      busy           <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.rsp_carry  <= 1'b0;
      bus.bus_data_o <= '0;
      bus.bus_ctrl_o <= '0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      func_q         <= func_d;
      carry_q        <= carry_d;
      bus.req_ready  <= (state_d == IDLE);
      busy           <= (state_d != IDLE);
      bus.rsp_valid  <= rsp_valid_d;
      bus.rsp_result <= rsp_result_d;
      bus.rsp_flags  <= rsp_flags_d;
      bus.rsp_carry  <= rsp_carry_d;
      bus.bus_data_o <= bus_data_d;
      bus.bus_ctrl_o <= bus_ctrl_d;
    end
  end

endmodule
